fifo_axis_packetizer: RTL and testbench
=======================================

// Module: fifo_axis_packetizer
// PURPOSE
//  Read-side drain stage of the async FIFO, in the FIFO read clock domain. Pops words with
//  the FIFO's registered-read protocol and re-emits them as an AXI-Stream master. Packets
//  close (TLAST) after PKT_LEN beats, or early when the FIFO stays idle for IDLE_TIMEOUT
//  cycles, so that the serializer downstream always sees framed packets.
// PARAMETERS
//  DATA_W        8   width of FIFO words and of o_tdata
//  PKT_LEN       16  max beats per packet; must be >= 2
//  IDLE_TIMEOUT  8   consecutive idle cycles before a held last beat is flushed; must be >= 1
// PORTS
//  i_clk         in   1       clock (FIFO read clock)
//  i_rst         in   1       asynchronous, active-high reset
//  o_fifo_rd     out  1       pop request to FIFO read port
//  i_fifo_rdata  in   DATA_W  FIFO read data; valid the cycle after an accepted pop
//  i_fifo_empty  in   1       FIFO empty flag
//  o_tvalid      out  1       AXIS valid
//  i_tready      in   1       AXIS ready
//  o_tdata       out  DATA_W  AXIS data
//  o_tlast       out  1       AXIS last beat of packet
//  o_beat_idx    out  $clog2(PKT_LEN)  index of the beat on o_tdata within its packet
// BEHAVIOUR
//  - Reset: o_tvalid=0, o_tlast=0, o_tdata=0, o_beat_idx=0, o_fifo_rd=0; buffer empty, idle timer 0.
//    Reset mid-packet discards all buffered and in-flight words. No partial TLAST is emitted.
//  - Pop: o_fifo_rd = !i_fifo_empty && (occ + inflight) < 3. The buffer is 3 entries
//    deep, including the output register. A pop issued in cycle N writes i_fifo_rdata
//    into the buffer at edge N+1. Never pop while i_fifo_empty=1.
//  - The buffer is an in-order FIFO. Its head is the candidate beat. Its beat index k
//    counts 0..PKT_LEN-1.
//  - State machine:
//    - IDLE: occ=0.
//    - HOLD: head is known but may not be presented, because its TLAST is undecided.
//    - SEND: o_tvalid=1.
//  - HOLD -> SEND, with TLAST chosen as follows:
//    - k==PKT_LEN-1: TLAST=1, present immediately.
//    - A second word is buffered or in flight: TLAST=0.
//    - Idle timer reaches IDLE_TIMEOUT: TLAST=1 (early close).
//  - Idle timer:
//    - Counts cycles in HOLD with occ==1, no pop in flight, and i_fifo_empty=1.
//    - Clears when any of those conditions drops. Saturates at IDLE_TIMEOUT.
//    - If a word arrives in the same cycle the timer expires, the arrival wins: TLAST=0.
//  - SEND:
//    - o_tdata, o_tlast and o_beat_idx are held stable until o_tvalid && i_tready.
//    - o_tvalid never drops without a handshake.
//    - On handshake the head pops. After TLAST, k resets to 0; otherwise k increments.
//    - Next state is SEND, HOLD or IDLE per the rules above. Back-to-back beats give
//      one beat per cycle.
//  - Latency: the first word from a non-empty FIFO reaches o_tvalid at 3 edges
//    (pop, capture, decide), or later if the successor or timeout is pending.
//  - Simultaneous handshake and arrival in the same cycle: both take effect; occ is unchanged.
//  - Throughput: 1 beat/cycle sustained while the FIFO stays non-empty and i_tready=1.
//  - Backpressure: with i_tready=0, pops stop once occ+inflight=3. No word is lost or duplicated.
// TESTING
//  - Reset with the FIFO holding 0x11..0x14 -> all outputs 0. After release, beats
//    0x11,0x12,0x13 go out with TLAST=0. 0x14 goes out with TLAST=1 after 8 idle cycles.
//  - Feed 32 words 0x00..0x1F continuously with i_tready=1 -> two packets of 16 beats.
//    TLAST on 0x0F and 0x1F; o_beat_idx wraps 15->0; no bubbles in steady state.
//  - i_tready=0 for 20 cycles with the FIFO full -> exactly 3 pops, then o_fifo_rd=0.
//    o_tdata is stable throughout. Releasing i_tready gives data in order with no loss.
//  - Single word 0xA5 -> held; TLAST=1 at idle count 8. Variant: a second word 0x5A
//    arrives at idle count 8 -> 0xA5 goes out with TLAST=0.
//  - Randomly toggle i_tready at 50% over 1000 words -> scoreboard matches in order;
//    each packet has <=16 beats; o_fifo_rd never asserts while empty.
//  - Assert i_rst in SEND mid-packet -> o_tvalid drops asynchronously. After release,
//    the next packet restarts at o_beat_idx=0.

Source files
------------

// File: rtl/fifo_axis_packetizer.sv
// fifo_axis_packetizer
// Drains the read port of an async FIFO (registered-read protocol) and emits the
// words as an AXI-Stream master. Packets are closed with TLAST after PKT_LEN beats,
// or early when the FIFO has stayed idle for IDLE_TIMEOUT cycles while one word is
// held, so the downstream serializer always sees framed packets.
//
// Handshake: a beat transfers on a rising edge where o_tvalid && i_tready. Once
// o_tvalid is raised, o_tvalid, o_tdata, o_tlast and o_beat_idx stay unchanged until
// that transfer happens; o_tvalid never depends combinationally on i_tready.
module fifo_axis_packetizer #(
  parameter int DATA_W       = 8,
  parameter int PKT_LEN      = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_fifo_rd,
  input  logic [DATA_W-1:0]          i_fifo_rdata,
  input  logic                       i_fifo_empty,
  output logic                       o_tvalid,
  input  logic                       i_tready,
  output logic [DATA_W-1:0]          o_tdata,
  output logic                       o_tlast,
  output logic [$clog2(PKT_LEN)-1:0] o_beat_idx,
  output logic [1:0]                 o_dbg_state
);

  localparam int KW = $clog2(PKT_LEN);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  // IDLE: nothing buffered. HOLD: head known but its TLAST is still undecided.
  // SEND: head presented on the AXIS port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_tvalid;
  logic              r_tlast;
  logic              w_tlast_nxt;
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     w_k_nxt;
  logic [TW-1:0]     r_idle;
  logic [TW-1:0]     w_idle_nxt;

  // Three-entry in-order buffer; entry 0 is the head and doubles as the output register.
  logic [DATA_W-1:0] r_mem [3];
  logic [1:0]        r_occ;
  logic [1:0]        w_occ_nxt;
  logic [1:0]        w_wr_idx;
  logic              r_inflight;

  logic              w_pop;
  logic              w_hs;
  logic              w_cap;
  logic              w_succ;
  logic              w_idle_cond;
  logic              w_expired;

  // Pop only when the buffer is guaranteed room for every word already requested.
  // Reset gates the request so nothing is popped while the block is held in reset.
  assign w_pop = !i_rst && !i_fifo_empty &&
                 (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);

  assign w_hs      = r_tvalid && i_tready;
  assign w_cap     = r_inflight;
  assign w_occ_nxt = r_occ + {1'b0, w_cap} - {1'b0, w_hs};
  assign w_wr_idx  = r_occ - {1'b0, w_hs};

  // Beat index of the word that will be the head after this edge.
  assign w_k_nxt = w_hs ? (r_tlast ? '0 : r_k + KW'(1)) : r_k;

  // A successor exists if it is already buffered behind the next head or is being
  // popped right now (its data lands next cycle).
  assign w_succ = (w_occ_nxt >= 2'd2) || w_pop;

  // The idle timer only runs while a lone held word has nothing coming behind it.
  assign w_idle_cond = (r_state == ST_HOLD) && (r_occ == 2'd1) && !r_inflight && i_fifo_empty;
  assign w_expired   = (r_state == ST_HOLD) && (r_idle == TW'(IDLE_TIMEOUT));

  // Next-state and TLAST decision for the head that will exist after this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_tlast_nxt = r_tlast;
    if (r_state == ST_SEND && !i_tready) begin
      // presented beat not yet taken: hold everything
      w_state_nxt = ST_SEND;
      w_tlast_nxt = r_tlast;
    end else if (w_occ_nxt == 2'd0) begin
      w_state_nxt = ST_IDLE;
      w_tlast_nxt = 1'b0;
    end else if (r_state == ST_IDLE) begin
      // a word was just captured into an empty buffer; decide on the next edge
      w_state_nxt = ST_HOLD;
      w_tlast_nxt = 1'b0;
    end else if (w_k_nxt == KW'(PKT_LEN - 1)) begin
      w_state_nxt = ST_SEND;
      w_tlast_nxt = 1'b1;
    end else if (w_succ) begin
      // an arrival coinciding with timer expiry lands here first, so it wins
      w_state_nxt = ST_SEND;
      w_tlast_nxt = 1'b0;
    end else if (w_expired) begin
      w_state_nxt = ST_SEND;
      w_tlast_nxt = 1'b1;
    end else begin
      w_state_nxt = ST_HOLD;
      w_tlast_nxt = 1'b0;
    end
  end

  // Saturating idle timer; cleared whenever its qualifying condition drops.
  always_comb begin
    w_idle_nxt = '0;
    if (w_idle_cond && w_state_nxt == ST_HOLD) begin
      w_idle_nxt = (r_idle == TW'(IDLE_TIMEOUT)) ? r_idle : r_idle + TW'(1);
    end
  end

  // Packetizer FSM with registered AXIS control outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_k      <= '0;
      r_idle   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tvalid <= (w_state_nxt == ST_SEND);
      r_tlast  <= w_tlast_nxt;
      r_k      <= w_k_nxt;
      r_idle   <= w_idle_nxt;
    end
  end

  // Buffer storage: shift on handshake, append the captured FIFO word behind the rest.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) begin
        r_mem[i] <= '0;
      end
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      r_occ      <= w_occ_nxt;
      if (w_hs) begin
        r_mem[0] <= r_mem[1];
        r_mem[1] <= r_mem[2];
      end
      if (w_cap) begin
        r_mem[w_wr_idx] <= i_fifo_rdata;
      end
    end
  end

  assign o_fifo_rd   = w_pop;
  assign o_tvalid    = r_tvalid;
  assign o_tdata     = r_mem[0];
  assign o_tlast     = r_tlast;
  assign o_beat_idx  = r_k;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Bench for fifo_axis_packetizer: a FIFO read-port model feeds the DUT, a monitor
// records AXIS beats and checks hold-stability, and each test task compares the
// recorded beats against hand-derived expectations.
module tb_fifo_axis_packetizer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       o_fifo_rd;
  logic [7:0] i_fifo_rdata = 8'h00;
  logic       i_fifo_empty = 1'b1;
  logic       o_tvalid;
  logic       i_tready;
  logic [7:0] o_tdata;
  logic       o_tlast;
  logic [3:0] o_beat_idx;
  logic [1:0] o_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_pops = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_word;

  logic [7:0] obs_data[$];
  logic       obs_last[$];
  logic [3:0] obs_idx[$];
  int         obs_cyc[$];

  logic       stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;
  logic [3:0] stall_idx;

  fifo_axis_packetizer #(
    .DATA_W(8),
    .PKT_LEN(16),
    .IDLE_TIMEOUT(8)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .o_fifo_rd(o_fifo_rd),
    .i_fifo_rdata(i_fifo_rdata),
    .i_fifo_empty(i_fifo_empty),
    .o_tvalid(o_tvalid),
    .i_tready(i_tready),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .o_beat_idx(o_beat_idx),
    .o_dbg_state(o_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  // FIFO read-port model: registered read data, empty flag updated at the clock edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_fifo_rd) begin
      n_cmp++;
      if (fifo_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_rd_while_empty: o_fifo_rd=1 required 0 at cycle %0d", cyc);
      end else begin
        model_word = fifo_q.pop_front();
        i_fifo_rdata <= model_word;
        n_pops++;
      end
    end
    i_fifo_empty <= (fifo_q.size() == 0);
  end

  // AXIS monitor: record beats, check that a stalled beat holds steady
  always @(negedge clk) begin
    if (i_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if (o_tvalid !== 1'b1 || o_tdata !== stall_data || o_tlast !== stall_last ||
            o_beat_idx !== stall_idx) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b i=%0d, required v=1 d=%h l=%b i=%0d",
                   o_tvalid, o_tdata, o_tlast, o_beat_idx, stall_data, stall_last, stall_idx);
        end
      end
      if (o_tvalid && i_tready) begin
        obs_data.push_back(o_tdata);
        obs_last.push_back(o_tlast);
        obs_idx.push_back(o_beat_idx);
        obs_cyc.push_back(cyc);
      end
      stall_prev = o_tvalid && !i_tready;
      stall_data = o_tdata;
      stall_last = o_tlast;
      stall_idx  = o_beat_idx;
    end
  end

  // driver helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    obs_idx.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t;
    t = 0;
    while (obs_data.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    n_cmp++;
    if (obs_data.size() < n) begin
      n_fail++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", obs_data.size(), n);
    end
  endtask

  // reset with words waiting, then drain: three chained beats and a timed-out last beat
  task automatic test_reset();
    logic [7:0] ed[4];
    logic       el[4];
    logic [3:0] ei[4];
    int         eo[4];
    int         c0;
    ed = '{8'h11, 8'h12, 8'h13, 8'h14};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    ei = '{4'd0, 4'd1, 4'd2, 4'd3};
    // pop, capture, decide = 3 edges; 0x14 waits 8 idle counts plus HOLD entry and decide
    eo = '{3, 4, 5, 15};
    for (int i = 0; i < 4; i++) fifo_q.push_back(ed[i]);
    tick(3);
    n_cmp += 5;
    if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b required 0", o_tvalid); end
    if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b required 0", o_tlast); end
    if (o_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_tdata: got %h required 00", o_tdata); end
    if (o_beat_idx !== 4'd0) begin n_fail++; $display("FAIL rst_beat_idx: got %0d required 0", o_beat_idx); end
    if (o_fifo_rd !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_rd: got %b required 0", o_fifo_rd); end
    clear_obs();
    i_tready = 1'b1;
    i_rst = 1'b0;
    c0 = cyc;
    wait_beats(4, 40);
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== ed[i] || obs_last[i] !== el[i] || obs_idx[i] !== ei[i] ||
          obs_cyc[i] - c0 != eo[i]) begin
        n_fail++;
        $display("FAIL rst_drain[%0d]: got d=%h l=%b i=%0d t=%0d, required d=%h l=%b i=%0d t=%0d",
                 i, obs_data[i], obs_last[i], obs_idx[i], obs_cyc[i] - c0, ed[i], el[i], ei[i], eo[i]);
      end
    end
    tick(2);
  endtask

  // 32 continuous words -> two full packets, one beat per cycle
  task automatic test_two_packets();
    clear_obs();
    i_tready = 1'b1;
    for (int i = 0; i < 32; i++) fifo_q.push_back(8'(i));
    wait_beats(32, 100);
    for (int i = 0; i < 32 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== 8'(i) || obs_idx[i] !== 4'(i % 16) || obs_last[i] !== (i % 16 == 15)) begin
        n_fail++;
        $display("FAIL pkt_beat[%0d]: got d=%h l=%b i=%0d, required d=%h l=%b i=%0d",
                 i, obs_data[i], obs_last[i], obs_idx[i], 8'(i), (i % 16 == 15), i % 16);
      end
      if (i > 0) begin
        n_cmp++;
        if (obs_cyc[i] - obs_cyc[i-1] != 1) begin
          n_fail++;
          $display("FAIL pkt_bubble[%0d]: got gap %0d required 1", i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
    tick(2);
  endtask

  // backpressure: buffer fills to 3, pops stop, head held, then in-order drain
  task automatic test_backpressure();
    clear_obs();
    i_tready = 1'b0;
    n_pops = 0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'h40 + 8'(i));
    tick(20);
    n_cmp += 4;
    if (n_pops != 3) begin n_fail++; $display("FAIL bp_pops: got %0d required 3", n_pops); end
    if (o_fifo_rd !== 1'b0) begin n_fail++; $display("FAIL bp_fifo_rd: got %b required 0", o_fifo_rd); end
    if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid: got %b required 1", o_tvalid); end
    if (o_tdata !== 8'h40 || o_beat_idx !== 4'd0 || o_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_head: got d=%h i=%0d l=%b required d=40 i=0 l=0", o_tdata, o_beat_idx, o_tlast);
    end
    i_tready = 1'b1;
    wait_beats(6, 60);
    for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== 8'h40 + 8'(i) || obs_idx[i] !== 4'(i) || obs_last[i] !== (i == 5)) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got d=%h l=%b i=%0d, required d=%h l=%b i=%0d",
                 i, obs_data[i], obs_last[i], obs_idx[i], 8'h40 + 8'(i), (i == 5), i);
      end
    end
    tick(2);
  endtask

  // lone word closes its packet by idle timeout
  task automatic test_single_word_timeout();
    int c0;
    clear_obs();
    i_tready = 1'b1;
    fifo_q.push_back(8'hA5);
    c0 = cyc;
    wait_beats(1, 40);
    // empty flag drops 1 edge later, then pop/capture, 8 idle counts, decide = 12
    if (obs_data.size() >= 1) begin
      n_cmp++;
      if (obs_data[0] !== 8'hA5 || obs_last[0] !== 1'b1 || obs_idx[0] !== 4'd0 || obs_cyc[0] - c0 != 12) begin
        n_fail++;
        $display("FAIL single_timeout: got d=%h l=%b i=%0d t=%0d, required d=a5 l=1 i=0 t=12",
                 obs_data[0], obs_last[0], obs_idx[0], obs_cyc[0] - c0);
      end
    end
    tick(2);
  endtask

  // second word arrives exactly at idle count 8: arrival wins, first beat has no TLAST
  task automatic test_single_word_arrival();
    int c0;
    clear_obs();
    i_tready = 1'b1;
    fifo_q.push_back(8'hA5);
    c0 = cyc;
    tick(10);
    fifo_q.push_back(8'h5A);
    wait_beats(2, 60);
    if (obs_data.size() >= 2) begin
      n_cmp += 2;
      if (obs_data[0] !== 8'hA5 || obs_last[0] !== 1'b0 || obs_idx[0] !== 4'd0 || obs_cyc[0] - c0 != 12) begin
        n_fail++;
        $display("FAIL arrival_first: got d=%h l=%b i=%0d t=%0d, required d=a5 l=0 i=0 t=12",
                 obs_data[0], obs_last[0], obs_idx[0], obs_cyc[0] - c0);
      end
      if (obs_data[1] !== 8'h5A || obs_last[1] !== 1'b1 || obs_idx[1] !== 4'd1 || obs_cyc[1] - c0 != 22) begin
        n_fail++;
        $display("FAIL arrival_second: got d=%h l=%b i=%0d t=%0d, required d=5a l=1 i=1 t=22",
                 obs_data[1], obs_last[1], obs_idx[1], obs_cyc[1] - c0);
      end
    end
    tick(2);
  endtask

  // 1000 words, bursty arrivals, 50% ready: order, framing and beat index
  task automatic test_random();
    int         pushed;
    int         t;
    int         k;
    logic [7:0] w;
    logic [7:0] e;
    clear_obs();
    exp_q.delete();
    pushed = 0;
    while (pushed < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        w = 8'($urandom_range(0, 255));
        fifo_q.push_back(w);
        exp_q.push_back(w);
        pushed++;
      end
      i_tready = ($urandom_range(0, 1) == 1);
      tick(1);
    end
    t = 0;
    while (obs_data.size() < 1000 && t < 20000) begin
      i_tready = ($urandom_range(0, 1) == 1);
      tick(1);
      t++;
    end
    i_tready = 1'b1;
    n_cmp++;
    if (obs_data.size() != 1000) begin
      n_fail++;
      $display("FAIL rand_count: got %0d beats required 1000", obs_data.size());
    end
    k = 0;
    for (int i = 0; i < obs_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_cmp += 2;
      if (obs_data[i] !== e) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got %h required %h", i, obs_data[i], e);
      end
      if (obs_idx[i] !== 4'(k) || (k == 15 && obs_last[i] !== 1'b1)) begin
        n_fail++;
        $display("FAIL rand_frame[%0d]: got i=%0d l=%b required i=%0d%s",
                 i, obs_idx[i], obs_last[i], k, (k == 15) ? " l=1" : "");
      end
      k = (obs_last[i] === 1'b1 || k == 15) ? 0 : k + 1;
    end
    tick(2);
  endtask

  // reset while a packet is being sent; the next packet restarts at beat 0
  task automatic test_reset_mid_packet();
    clear_obs();
    i_tready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h60 + 8'(i));
    wait_beats(3, 40);
    n_cmp++;
    if (o_tvalid !== 1'b1 || o_beat_idx !== 4'd3) begin
      n_fail++;
      $display("FAIL midrst_pre: got v=%b i=%0d required v=1 i=3", o_tvalid, o_beat_idx);
    end
    i_rst = 1'b1;
    #1;
    n_cmp += 3;
    if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %b required 0", o_tvalid); end
    if (o_beat_idx !== 4'd0) begin n_fail++; $display("FAIL midrst_idx: got %0d required 0", o_beat_idx); end
    if (o_fifo_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo_rd: got %b required 0", o_fifo_rd); end
    fifo_q.delete();
    tick(3);
    i_rst = 1'b0;
    clear_obs();
    fifo_q.push_back(8'h70);
    fifo_q.push_back(8'h71);
    wait_beats(2, 40);
    if (obs_data.size() >= 2) begin
      n_cmp += 2;
      if (obs_data[0] !== 8'h70 || obs_idx[0] !== 4'd0 || obs_last[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_next0: got d=%h i=%0d l=%b required d=70 i=0 l=0", obs_data[0], obs_idx[0], obs_last[0]);
      end
      if (obs_data[1] !== 8'h71 || obs_idx[1] !== 4'd1 || obs_last[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_next1: got d=%h i=%0d l=%b required d=71 i=1 l=1", obs_data[1], obs_idx[1], obs_last[1]);
      end
    end
    tick(2);
  endtask

  initial begin
    i_rst    = 1'b1;
    i_tready = 1'b0;
    test_reset();
    test_two_packets();
    test_backpressure();
    test_single_word_timeout();
    test_single_word_arrival();
    test_random();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
